// File: rtl/edge_collision_checker.sv
// Walks the Bresenham cells of segment (x0,y0)->(x1,y1) and queries the occupancy
// grid one cell at a time, stopping at the first occupied cell.
module edge_collision_checker #(
  parameter int unsigned GRID_WIDTH_LOG2  = 6,
  parameter int unsigned GRID_HEIGHT_LOG2 = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [GRID_WIDTH_LOG2-1:0]  x0_in,
  input  logic [GRID_HEIGHT_LOG2-1:0] y0_in,
  input  logic [GRID_WIDTH_LOG2-1:0]  x1_in,
  input  logic [GRID_HEIGHT_LOG2-1:0] y1_in,
  output logic                        rdy,
  output logic                        done,
  output logic                        collision,
  output logic [GRID_WIDTH_LOG2-1:0]  hit_x,
  output logic [GRID_HEIGHT_LOG2-1:0] hit_y,
  output logic [((GRID_WIDTH_LOG2 > GRID_HEIGHT_LOG2) ? GRID_WIDTH_LOG2 : GRID_HEIGHT_LOG2):0] cells_checked,
  output logic [GRID_WIDTH_LOG2-1:0]  grid_cell_x,
  output logic [GRID_HEIGHT_LOG2-1:0] grid_cell_y,
  output logic                        grid_vld,
  output logic                        grid_we,
  output logic                        grid_w_occ,
  input  logic                        grid_rdy,
  input  logic                        grid_vld_out,
  input  logic                        grid_r_occ
);

  localparam int unsigned XW = GRID_WIDTH_LOG2;
  localparam int unsigned YW = GRID_HEIGHT_LOG2;
  localparam int unsigned CW = (XW > YW) ? XW : YW;
  localparam int unsigned DW = CW + 2;
  localparam int unsigned EW = DW + 1;
  localparam int unsigned NW = CW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [XW-1:0]         r_cur_x, w_cur_x_nxt;
  logic [YW-1:0]         r_cur_y, w_cur_y_nxt;
  logic [XW-1:0]         r_end_x, w_end_x_nxt;
  logic [YW-1:0]         r_end_y, w_end_y_nxt;
  logic signed [DW-1:0]  r_dx, w_dx_nxt;
  logic signed [DW-1:0]  r_dy, w_dy_nxt;
  logic signed [DW-1:0]  r_err, w_err_nxt;
  logic                  r_sx_neg, w_sx_neg_nxt;
  logic                  r_sy_neg, w_sy_neg_nxt;
  logic                  r_collision, w_collision_nxt;
  logic [XW-1:0]         r_hit_x, w_hit_x_nxt;
  logic [YW-1:0]         r_hit_y, w_hit_y_nxt;
  logic [NW-1:0]         r_cells, w_cells_nxt;
  logic                  r_rdy, w_rdy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_grid_vld, w_grid_vld_nxt;

  // Segment setup from the raw endpoints: dx = |x1-x0|, dy = -|y1-y0|.
  logic signed [DW-1:0]  w_x0_s, w_x1_s, w_y0_s, w_y1_s;
  logic signed [DW-1:0]  w_dx_diff, w_dy_diff, w_dx_init, w_dy_init;

  assign w_x0_s    = DW'(x0_in);
  assign w_x1_s    = DW'(x1_in);
  assign w_y0_s    = DW'(y0_in);
  assign w_y1_s    = DW'(y1_in);
  assign w_dx_diff = w_x1_s - w_x0_s;
  assign w_dy_diff = w_y1_s - w_y0_s;
  assign w_dx_init = w_dx_diff[DW-1] ? -w_dx_diff : w_dx_diff;
  assign w_dy_init = w_dy_diff[DW-1] ? w_dy_diff : -w_dy_diff;

  // e2 = 2*err can exceed the err range, so it carries one extra bit.
  logic signed [EW-1:0]  w_e2, w_dx_e, w_dy_e;
  logic                  w_step_x, w_step_y, w_at_end;
  logic signed [DW-1:0]  w_err_step;

  assign w_e2       = $signed({r_err, 1'b0});
  assign w_dx_e     = $signed({r_dx[DW-1], r_dx});
  assign w_dy_e     = $signed({r_dy[DW-1], r_dy});
  assign w_step_x   = (w_e2 >= w_dy_e);
  assign w_step_y   = (w_e2 <= w_dx_e);
  assign w_err_step = r_err + (w_step_x ? r_dy : DW'(0)) + (w_step_y ? r_dx : DW'(0));
  assign w_at_end   = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_x_nxt     = r_cur_x;
    w_cur_y_nxt     = r_cur_y;
    w_end_x_nxt     = r_end_x;
    w_end_y_nxt     = r_end_y;
    w_dx_nxt        = r_dx;
    w_dy_nxt        = r_dy;
    w_err_nxt       = r_err;
    w_sx_neg_nxt    = r_sx_neg;
    w_sy_neg_nxt    = r_sy_neg;
    w_collision_nxt = r_collision;
    w_hit_x_nxt     = r_hit_x;
    w_hit_y_nxt     = r_hit_y;
    w_cells_nxt     = r_cells;
    w_rdy_nxt       = r_rdy;
    w_done_nxt      = 1'b0;
    w_grid_vld_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cur_x_nxt     = x0_in;
          w_cur_y_nxt     = y0_in;
          w_end_x_nxt     = x1_in;
          w_end_y_nxt     = y1_in;
          w_dx_nxt        = w_dx_init;
          w_dy_nxt        = w_dy_init;
          w_err_nxt       = w_dx_init + w_dy_init;
          w_sx_neg_nxt    = (x1_in < x0_in);
          w_sy_neg_nxt    = (y1_in < y0_in);
          w_cells_nxt     = '0;
          w_collision_nxt = 1'b0;
          w_hit_x_nxt     = '0;
          w_hit_y_nxt     = '0;
          w_rdy_nxt       = 1'b0;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (grid_rdy) begin
          w_grid_vld_nxt = 1'b1;
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (grid_vld_out) begin
          w_cells_nxt = r_cells + NW'(1);
          if (grid_r_occ) begin
            w_collision_nxt = 1'b1;
            w_hit_x_nxt     = r_cur_x;
            w_hit_y_nxt     = r_cur_y;
            w_done_nxt      = 1'b1;
            w_state_nxt     = S_DONE;
          end else if (w_at_end) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_STEP;
          end
        end
      end
      S_STEP: begin
        w_err_nxt = w_err_step;
        if (w_step_x) begin
          w_cur_x_nxt = r_sx_neg ? (r_cur_x - XW'(1)) : (r_cur_x + XW'(1));
        end
        if (w_step_y) begin
          w_cur_y_nxt = r_sy_neg ? (r_cur_y - YW'(1)) : (r_cur_y + YW'(1));
        end
        w_state_nxt = S_ISSUE;
      end
      S_DONE: begin
        w_rdy_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_rdy_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_end_x     <= '0;
      r_end_y     <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_sx_neg    <= 1'b0;
      r_sy_neg    <= 1'b0;
      r_collision <= 1'b0;
      r_hit_x     <= '0;
      r_hit_y     <= '0;
      r_cells     <= '0;
      r_rdy       <= 1'b1;
      r_done      <= 1'b0;
      r_grid_vld  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_x     <= w_cur_x_nxt;
      r_cur_y     <= w_cur_y_nxt;
      r_end_x     <= w_end_x_nxt;
      r_end_y     <= w_end_y_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_err       <= w_err_nxt;
      r_sx_neg    <= w_sx_neg_nxt;
      r_sy_neg    <= w_sy_neg_nxt;
      r_collision <= w_collision_nxt;
      r_hit_x     <= w_hit_x_nxt;
      r_hit_y     <= w_hit_y_nxt;
      r_cells     <= w_cells_nxt;
      r_rdy       <= w_rdy_nxt;
      r_done      <= w_done_nxt;
      r_grid_vld  <= w_grid_vld_nxt;
    end
  end

  assign rdy           = r_rdy;
  assign done          = r_done;
  assign collision     = r_collision;
  assign hit_x         = r_hit_x;
  assign hit_y         = r_hit_y;
  assign cells_checked = r_cells;
  assign grid_cell_x   = r_cur_x;
  assign grid_cell_y   = r_cur_y;
  assign grid_vld      = r_grid_vld;
  assign grid_we       = 1'b0;
  assign grid_w_occ    = 1'b0;

endmodule
